// File: rtl/imm_ext_arbiter_pkg.sv
// Shared constants and FSM encoding for the immediate-extender arbiter.
package imm_ext_arbiter_pkg;

  localparam int IMM_IN_W  = 5;
  localparam int IMM_OUT_W = 8;

  // 2'd3 is unreachable in normal operation; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

endpackage

// File: rtl/imm_ext_arbiter_signext_5to8.sv
// Existing 5-to-8 sign extender shared by the ALU and branch-offset paths.
module signext_5to8 (
  output logic [7:0] dOut,
  input  logic [4:0] dIn
);

  assign dOut = {{3{dIn[4]}}, dIn};

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one signext_5to8 between ALU-immediate (0) and branch-offset (1) paths.
// Grant one edge after request, registered result plus done pulse one edge later; one job per 3 cycles.
module imm_ext_arbiter
  import imm_ext_arbiter_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [IN_W-1:0]  din0,
  input  logic             sx0,
  input  logic             req1,
  input  logic [IN_W-1:0]  din1,
  input  logic             sx1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [OUT_W-1:0] dout,
  output logic             busy
);

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              win_q, win_d;
  logic [IN_W-1:0]   field_q, field_d;
  logic              sx_q, sx_d;
  logic [OUT_W-1:0]  dout_q, dout_d;

  logic              any_req;
  logic              pick;
  logic [OUT_W-1:0]  ext_out;
  logic [OUT_W-1:0]  ext_mux;

  assign any_req = req0 | req1;
  // A lone request wins outright; on contention rr_q names the favoured requester.
  assign pick    = (req0 & req1) ? rr_q : req1;

  signext_5to8 ext0 (
    .dOut (ext_out),
    .dIn  (field_q)
  );

  assign ext_mux = sx_q ? ext_out : {{(OUT_W-IN_W){1'b0}}, field_q};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = any_req ? ST_EXT : ST_IDLE;
      ST_EXT:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    busy  = (state_q != ST_IDLE);
    case (state_q)
      ST_EXT: begin
        gnt0 = ~win_q;
        gnt1 = win_q;
      end
      ST_DONE: begin
        gnt0  = ~win_q;
        gnt1  = win_q;
        done0 = ~win_q;
        done1 = win_q;
      end
      default: ;
    endcase
  end

  assign dout = dout_q;

  always_comb begin
    rr_d    = rr_q;
    win_d   = win_q;
    field_d = field_q;
    sx_d    = sx_q;
    dout_d  = dout_q;
    if (state_q == ST_IDLE && any_req) begin
      win_d   = pick;
      rr_d    = ~pick;
      field_d = pick ? din1 : din0;
      sx_d    = pick ? sx1  : sx0;
    end
    if (state_q == ST_EXT) begin
      dout_d = ext_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= 1'b0;
      win_q   <= 1'b0;
      field_q <= '0;
      sx_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      win_q   <= win_d;
      field_q <= field_d;
      sx_q    <= sx_d;
      dout_q  <= dout_d;
    end
  end

  a_gnt_onehot:  assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  a_done_onehot: assert property (@(posedge clk) disable iff (rst) !(done0 && done1));
  a_done0_gnt:   assert property (@(posedge clk) disable iff (rst) done0 |-> gnt0);
  a_done1_gnt:   assert property (@(posedge clk) disable iff (rst) done1 |-> gnt1);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Randomised and directed bench for imm_ext_arbiter against a transaction-level model.
module tb_imm_ext_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, sx0, req1, sx1;
  logic [4:0] din0, din1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] dout;

  int tests = 0;
  int fails = 0;

  // Model: jobs are tracked by how many edges have passed since the grant.
  int       m_age;
  bit       m_win, m_rr, m_sx;
  bit [4:0] m_field;
  bit [7:0] m_dout;

  imm_ext_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .din0  (din0),
    .sx0   (sx0),
    .req1  (req1),
    .din1  (din1),
    .sx1   (sx1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .dout  (dout),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] ref_ext(bit [4:0] f, bit s);
    int v;
    v = int'(f);
    if (s && v >= 16) v = v - 32;
    return 8'(v);
  endfunction

  task automatic model_reset();
    m_age = 0; m_rr = 0; m_win = 0; m_sx = 0; m_field = 0; m_dout = 0;
  endtask

  task automatic model_step();
    if (m_age == 0) begin
      if (req0 || req1) begin
        m_win   = (req0 && req1) ? m_rr : req1;
        m_rr    = !m_win;
        m_field = m_win ? din1 : din0;
        m_sx    = m_win ? sx1 : sx0;
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      m_dout = ref_ext(m_field, m_sx);
      m_age  = 2;
    end else begin
      m_age = 0;
    end
  endtask

  function automatic bit [12:0] model_outs();
    bit g0, g1, d0, d1, b;
    b  = (m_age != 0);
    g0 = b && !m_win;
    g1 = b && m_win;
    d0 = (m_age == 2) && !m_win;
    d1 = (m_age == 2) && m_win;
    return {g0, g1, d0, d1, b, m_dout};
  endfunction

  // Advance one clock edge and leave the caller at the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic run_one(input bit which, input logic [4:0] d, input bit s,
                         output logic [7:0] got, output int gnt_at, output int done_at,
                         output int busy_cycles, output bit done_who);
    got = 8'h00; gnt_at = -1; done_at = -1; busy_cycles = 0; done_who = 0;
    if (which) begin req1 = 1; din1 = d; sx1 = s; end
    else begin req0 = 1; din0 = d; sx0 = s; end
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (busy) busy_cycles++;
      if (gnt_at < 0 && (gnt0 || gnt1)) gnt_at = c;
      if (done0 || done1) begin
        done_at = c; got = dout; done_who = done1;
        break;
      end
    end
    req0 = 0; req1 = 0;
    tick();
    if (busy) busy_cycles++;
  endtask

  task automatic test_reset();
    rst = 1; req0 = 0; req1 = 0; din0 = 0; din1 = 0; sx0 = 0; sx1 = 0;
    model_reset();
    #1;
    tests++;
    if ({gnt0, gnt1, done0, done1, busy, dout} !== 13'h0) begin
      fails++; $display("FAIL reset_async: outs=%h expected 0", {gnt0, gnt1, done0, done1, busy, dout});
    end
    tick(); tick();
    tests++;
    if ({gnt0, gnt1, done0, done1, busy, dout} !== 13'h0) begin
      fails++; $display("FAIL reset_held: outs=%h expected 0", {gnt0, gnt1, done0, done1, busy, dout});
    end
    rst = 0;
  endtask

  task automatic test_sign_negative();
    logic [7:0] got; int ga, da, bc; bit who;
    run_one(0, 5'b11111, 1, got, ga, da, bc, who);
    tests++;
    if (ga !== 1 || da !== 2 || bc !== 2 || who !== 0) begin
      fails++; $display("FAIL sign_neg_timing: gnt@%0d done@%0d busy=%0d who=%0d expected 1 2 2 0", ga, da, bc, who);
    end
    tests++;
    if (got !== 8'hFF) begin
      fails++; $display("FAIL sign_neg_value: dout=%h expected ff", got);
    end
    tests++;
    if (busy !== 1'b0 || dout !== 8'hFF) begin
      fails++; $display("FAIL sign_neg_hold: busy=%0d dout=%h expected 0 ff", busy, dout);
    end
  endtask

  task automatic test_sign_vs_zero();
    logic [7:0] got; int ga, da, bc; bit who;
    logic [4:0] vin[3]  = '{5'b10000, 5'b10000, 5'b01111};
    bit         vsx[3]  = '{1'b1, 1'b0, 1'b1};
    logic [7:0] vexp[3] = '{8'hF0, 8'h10, 8'h0F};
    for (int i = 0; i < 3; i++) begin
      run_one(1, vin[i], vsx[i], got, ga, da, bc, who);
      tests++;
      if (got !== vexp[i] || who !== 1'b1 || da !== 2) begin
        fails++; $display("FAIL sx_zx_%0d: dout=%h who=%0d done@%0d expected %h 1 2", i, got, who, da, vexp[i]);
      end
    end
  endtask

  task automatic test_contention();
    int         when[$];
    bit         who[$];
    logic [7:0] val[$];
    bit         clash;
    @(negedge clk); rst = 1; #1; rst = 0; model_reset();
    din0 = 5'b00001; sx0 = 0; din1 = 5'b11110; sx1 = 1;
    req0 = 1; req1 = 1;
    clash = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if ((gnt0 && gnt1) || (done0 && done1)) clash = 1;
      if (done0 || done1) begin
        when.push_back(c); who.push_back(done1); val.push_back(dout);
      end
    end
    req0 = 0; req1 = 0;
    tests++;
    if (when.size() != 4 || clash) begin
      fails++; $display("FAIL contention_count: dones=%0d clash=%0d expected 4 0", when.size(), clash);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (who[i] !== bit'(i % 2) || when[i] != 2 + 3 * i || val[i] !== ((i % 2) ? 8'hFE : 8'h01)) begin
          fails++;
          $display("FAIL contention_%0d: who=%0d cycle=%0d dout=%h expected %0d %0d %h",
                   i, who[i], when[i], val[i], i % 2, 2 + 3 * i, (i % 2) ? 8'hFE : 8'h01);
        end
      end
    end
  endtask

  task automatic test_mid_change();
    int pulses;
    req0 = 1; din0 = 5'b00101; sx0 = 1; req1 = 0;
    tick();
    tests++;
    if (gnt0 !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL mid_grant: gnt0=%0d busy=%0d expected 1 1", gnt0, busy);
    end
    din0 = 5'b00000; req0 = 0;
    pulses = 0;
    tick();
    if (done0) pulses++;
    tests++;
    if (done0 !== 1'b1 || dout !== 8'h05) begin
      fails++; $display("FAIL mid_value: done0=%0d dout=%h expected 1 05", done0, dout);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done0) pulses++;
    end
    tests++;
    if (pulses != 1 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_single_pulse: pulses=%0d busy=%0d expected 1 0", pulses, busy);
    end
  endtask

  task automatic test_async_reset();
    int         order[$];
    logic [7:0] vals[$];
    req0 = 1; din0 = 5'b01010; sx0 = 0; req1 = 0;
    tick();
    req1 = 1; din1 = 5'b10101; sx1 = 1;
    tests++;
    if (gnt0 !== 1'b1) begin
      fails++; $display("FAIL areset_setup: gnt0=%0d expected 1", gnt0);
    end
    #2 rst = 1;
    #1;
    model_reset();
    tests++;
    if ({gnt0, gnt1, done0, done1, busy, dout} !== 13'h0) begin
      fails++; $display("FAIL areset_drop: outs=%h expected 0", {gnt0, gnt1, done0, done1, busy, dout});
    end
    tick();
    tests++;
    if (done0 !== 1'b0 || done1 !== 1'b0 || dout !== 8'h00) begin
      fails++; $display("FAIL areset_no_done: done0=%0d done1=%0d dout=%h expected 0 0 00", done0, done1, dout);
    end
    rst = 0;
    for (int c = 0; c < 8 && order.size() < 2; c++) begin
      tick();
      if (done0 || done1) begin
        order.push_back(int'(done1)); vals.push_back(dout);
        if (done0) req0 = 0;
        if (done1) req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    tests++;
    if (order.size() != 2) begin
      fails++; $display("FAIL areset_resume: dones=%0d expected 2", order.size());
    end else if (order[0] != 0 || order[1] != 1 || vals[0] !== 8'h0A || vals[1] !== 8'hF5) begin
      fails++;
      $display("FAIL areset_resume: order=%0d,%0d douts=%h,%h expected 0,1 0a,f5", order[0], order[1], vals[0], vals[1]);
    end
    tick();
  endtask

  task automatic test_idle_hold();
    bit [12:0] exp;
    req0 = 0; req1 = 0;
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      exp = model_outs();
      tests++;
      if ({gnt0, gnt1, done0, done1, busy} !== 5'b0 || dout !== exp[7:0]) begin
        fails++; $display("FAIL idle_hold_%0d: ctl=%b dout=%h expected 00000 %h", c, {gnt0, gnt1, done0, done1, busy}, dout, exp[7:0]);
      end
    end
  endtask

  task automatic test_random();
    bit [12:0] exp;
    int        bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      req0 = ($urandom_range(0, 99) < 55);
      req1 = ($urandom_range(0, 99) < 55);
      din0 = 5'($urandom); din1 = 5'($urandom);
      sx0  = 1'($urandom); sx1  = 1'($urandom);
      tick();
      exp = model_outs();
      tests++;
      if ({gnt0, gnt1, done0, done1, busy, dout} !== exp) begin
        fails++;
        if (bad < 10) $display("FAIL random_%0d: outs=%h expected %h", c, {gnt0, gnt1, done0, done1, busy, dout}, exp);
        bad++;
      end
    end
    req0 = 0; req1 = 0;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_sign_negative();
    test_sign_vs_zero();
    test_contention();
    test_mid_change();
    test_async_reset();
    test_idle_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
Name: imm_ext_arbiter

Overview:
- Shares the single 5-to-8 immediate extender (signext_5to8) between two requesters: requester 0 is the ALU immediate path and requester 1 is the branch-offset path.
- Arbitrates between them round-robin, latches the chosen 5-bit field, and drives it through the extender.
- Returns a registered 8-bit result with a one-cycle done pulse to the winner.
- Sits between decode and the ALU/PC-adder operand muxes.

Parameters:
- IN_W, 5, width of the immediate field; fixed by the signext_5to8 port width.
- OUT_W, 8, datapath width of the extended result.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 requests an extension.
- din0  in  IN_W  requester 0 immediate field; must be stable while req0 is high.
- sx0  in  1  requester 0 mode: 1 = sign-extend, 0 = zero-extend.
- req1  in  1  requester 1 request.
- din1  in  IN_W  requester 1 immediate field.
- sx1  in  1  requester 1 mode.
- gnt0  out  1  requester 0 owns the extender (EXT and DONE states).
- gnt1  out  1  requester 1 owns the extender.
- done0  out  1  one-cycle pulse: dout is valid for requester 0.
- done1  out  1  one-cycle pulse: dout is valid for requester 1.
- dout  out  OUT_W  registered extended result; holds its value until the next completion.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0 (requester 0 favoured).
  - gnt0/1=0, done0/1=0, dout=8'h00, busy=0, field_q=0, sx_q=0.
- FSM states: IDLE -> EXT -> DONE -> IDLE. There is no other path.
- IDLE:
  - At the edge where any req is high, select the winner, latch its din into field_q and its sx into sx_q, set its gnt, and go to EXT.
  - If no req is high, stay in IDLE.
- Arbitration:
  - Only one request high: it wins.
  - Both high: the requester indicated by rr_ptr wins.
  - rr_ptr <= ~winner at the grant edge.
- EXT:
  - field_q drives the signext_5to8 instance.
  - Result mux: sx_q=1 selects the sub-module output; sx_q=0 selects {3'b000, field_q}.
  - At the next edge, dout <= mux output, the winner's done goes high, and state goes to DONE.
- DONE:
  - done and gnt of the winner stay high for exactly this one cycle.
  - At the next edge, gnt and done clear and state returns to IDLE.
- Latency and throughput:
  - Request sampled at edge E0; gnt is visible after E0; done and dout are visible after E1. That is 2 cycles from request to result.
  - One transaction per 3 cycles.
- Requester protocol:
  - Drop req in the cycle done is seen.
  - If req is still high when IDLE is re-entered, it counts as a new request. It is not merged with the previous one.
- Request deasserted while granted: the transaction completes anyway; done still pulses and dout updates.
- din changed after the grant edge: ignored, because field_q holds the sampled value.
- Reset asserted in EXT or DONE: immediate return to reset values, no done pulse, dout=8'h00.
- Reset release: first grant possible at the first rising edge with rst low.
- Invariants:
  - gnt0 and gnt1 are never both high.
  - done0 and done1 are never both high.
  - doneX implies gntX.
- Arithmetic: sign-extend replicates field_q[4] into bits 7:5; zero-extend fills bits 7:5 with 0. No other transformation.

Decomposition:
- Shared package/header holds:
  - State encodings: IDLE=2'd0, EXT=2'd1, DONE=2'd2. 2'd3 is illegal and recovers to IDLE.
  - IN_W/OUT_W constants.
- Single sub-module: the existing signext_5to8, instantiated once as ext0(dOut, dIn).
- The zero-extend mux stays in the arbiter; the extender is not modified.

Test Plan:
- Sign-extend, negative: req0=1, din0=5'b11111, sx0=1 -> gnt0 high after 1 edge; done0 pulse after 2 edges with dout=8'hFF; busy high for 2 cycles.
- Sign- vs zero-extend: req1, din1=5'b10000, sx1=1 -> dout=8'hF0. Repeat with sx1=0 -> dout=8'h10. din=5'b01111 with sx=1 -> dout=8'h0F.
- Contention: req0 and req1 both held high after reset.
  - Grant order is 0,1,0,1.
  - done pulses arrive every 3 cycles.
  - dout alternates between the din0 and din1 extensions (e.g. din0=5'b00001 -> 8'h01, din1=5'b11110 with sx=1 -> 8'hFE).
- Mid-transaction changes: during EXT, change din0 to 5'b00000 and drop req0 -> dout still reflects the originally latched value; done0 still pulses once.
- Async reset in EXT: assert rst between clock edges -> gnt, done and busy drop immediately; dout=8'h00; no done pulse. After release, a pending req1 is served with rr_ptr=0 priority rules.
- Idle hold: no requests for 10 cycles -> state stays IDLE, dout unchanged, no gnt or done activity.
